// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - Shared constants and types for the remote_comm command link.
// Holds response codes, command opcodes, default bit timing and the command FSM states.
package comm_pkg;

  localparam int DEFAULT_BAUD_DIV = 434;

  localparam logic [7:0] COMM_COMPLETE     = 8'hA5;
  localparam logic [7:0] COMM_INTERMEDIATE = 8'h5A;

  localparam logic [15:0] CALIBRATE = 16'h2000;
  localparam logic [15:0] MOVE      = 16'h4000;
  localparam logic [15:0] MOVE_FAN  = 16'h5000;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_LO
  } cmd_state_t;

endpackage

// File: rtl/uart_trx.sv
// rtl/uart_trx.sv - 8N1 UART transmitter and receiver, independent and full duplex.
// tx_done strobes in the last cycle of a stop bit so a caller can chain bytes gap-free.
module uart_trx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rdy,
  input  logic       clr_rdy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic          tx_busy;
  logic          tx_end;
  logic          tx_load;

  assign tx_end  = tx_busy && (tx_baud == BAUD_LAST) && (tx_bit == 4'd9);
  assign tx_load = trmt && (!tx_busy || tx_end);
  assign tx_done = tx_end;
  assign TX      = tx_shift[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_busy  <= 1'b0;
    end else if (tx_load) begin
      tx_shift <= {1'b1, tx_data, 1'b0};
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_busy  <= 1'b1;
    end else if (tx_busy) begin
      if (tx_baud == BAUD_LAST) begin
        tx_baud <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          tx_shift <= {1'b1, tx_shift[9:1]};
        end
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

  logic          rx_ff1, rx_ff2, rx_prev;
  logic          rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_start;
  logic          rx_sample;
  logic          rx_done;

  assign rx_start  = !rx_busy && rx_prev && !rx_ff2;
  assign rx_sample = rx_busy && (rx_cnt == '0);
  assign rx_done   = rx_sample && (rx_bit == 4'd9);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  // Bit 0 is the start bit (a high sample there is a glitch), 1..8 data, 9 stop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (rx_start) begin
      rx_busy <= 1'b1;
      rx_cnt  <= HALF_LAST;
      rx_bit  <= '0;
    end else if (rx_sample) begin
      rx_cnt <= BAUD_LAST;
      rx_bit <= rx_bit + 4'd1;
      if (rx_bit == 4'd0) begin
        if (rx_ff2) rx_busy <= 1'b0;
      end else if (rx_bit == 4'd9) begin
        rx_busy <= 1'b0;
      end else begin
        rx_shift <= {rx_ff2, rx_shift[7:1]};
      end
    end else if (rx_busy) begin
      rx_cnt <= rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
    end else if (rx_done) begin
      rx_data <= rx_shift;
      rdy     <= 1'b1;
    end else if (clr_rdy || rx_start) begin
      rdy <= 1'b0;
    end
  end

endmodule

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - Host-side command link: 16-bit command as two UART bytes, one-byte responses.
// Optional macro REMOTE_COMM_AUTO_CLR_EN: an accepted send_cmd also clears resp_rdy.
module remote_comm
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_rx_rdy
);

  cmd_state_t state, next_state;
  logic [7:0] cmd_lo;
  logic [7:0] tx_byte;
  logic       trmt;
  logic       accept;
  logic       tx_done;
  logic       clr_rdy;

`ifdef REMOTE_COMM_AUTO_CLR_EN
  assign clr_rdy = clr_rx_rdy | accept;
`else
  assign clr_rdy = clr_rx_rdy;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_lo   <= 8'h00;
      cmd_sent <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        cmd_lo   <= cmd[7:0];
        cmd_sent <= 1'b0;
      end else if (state == SEND_LO && tx_done) begin
        cmd_sent <= 1'b1;
      end
    end
  end

  // The high byte goes straight from the input; only the low byte needs holding.
  always_comb begin
    next_state = state;
    trmt       = 1'b0;
    accept     = 1'b0;
    tx_byte    = cmd_lo;
    case (state)
      IDLE: begin
        if (send_cmd) begin
          accept     = 1'b1;
          trmt       = 1'b1;
          tx_byte    = cmd[15:8];
          next_state = SEND_HI;
        end
      end
      SEND_HI: begin
        if (tx_done) begin
          trmt       = 1'b1;
          next_state = SEND_LO;
        end
      end
      SEND_LO: begin
        if (tx_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .trmt    (trmt),
    .tx_data (tx_byte),
    .tx_done (tx_done),
    .rx_data (resp),
    .rdy     (resp_rdy),
    .clr_rdy (clr_rdy)
  );

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - Self-checking bench for remote_comm against a frame-level behavioural model.
module tb_remote_comm;

  localparam int B     = 434;
  localparam int FRAME = 10 * B;
`ifdef REMOTE_COMM_AUTO_CLR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd = 16'h0000;
  logic        send_cmd = 1'b0;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_rx_rdy = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .send_cmd   (send_cmd),
    .cmd_sent   (cmd_sent),
    .resp       (resp),
    .resp_rdy   (resp_rdy),
    .clr_rx_rdy (clr_rx_rdy)
  );

  always #5 clk = ~clk;

  // Model state: TX waveform is a pure function of the accept edge and the latched word.
  bit          m_active = 1'b0;
  int          acc_e = 0;
  logic [15:0] m_word = 16'h0000;
  logic        m_rdy = 1'b0;
  logic [7:0]  m_resp = 8'h00;
  int          det_e = -1;
  int          done_e = -1;
  logic [7:0]  rx_byte = 8'h00;
  bit          check_en = 1'b0;
  logic [7:0]  txq[$];

  function automatic bit model_idle(input int e);
    return !m_active || (e - acc_e > 2 * FRAME);
  endfunction

  function automatic logic frame_bit(input int off, input logic [15:0] w);
    logic [7:0] by;
    int k;
    by = (off < FRAME) ? w[15:8] : w[7:0];
    k  = (off % FRAME) / B;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return by[k-1];
  endfunction

  function automatic logic exp_tx();
    if (!m_active || (cyc - acc_e >= 2 * FRAME)) return 1'b1;
    return frame_bit(cyc - acc_e, m_word);
  endfunction

  function automatic logic exp_sent();
    return m_active && (cyc - acc_e >= 2 * FRAME);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_active <= 1'b0;
      m_rdy    <= 1'b0;
      m_resp   <= 8'h00;
    end else begin
      if (send_cmd && model_idle(cyc + 1)) begin
        acc_e    <= cyc + 1;
        m_word   <= cmd;
        m_active <= 1'b1;
      end
      if (cyc + 1 == done_e) begin
        m_rdy  <= 1'b1;
        m_resp <= rx_byte;
      end else if (clr_rx_rdy || (cyc + 1 == det_e) || (AUTO && send_cmd && model_idle(cyc + 1))) begin
        m_rdy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("tx", {15'd0, TX}, {15'd0, exp_tx()});
      chk("cmd_sent", {15'd0, cmd_sent}, {15'd0, exp_sent()});
      chk("resp_rdy", {15'd0, resp_rdy}, {15'd0, m_rdy});
      chk("resp", {8'd0, resp}, {8'd0, m_resp});
    end
  end

  // Independent TX decoder: mid-bit sampling of each 8N1 frame.
  initial begin : tx_mon
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && prev === 1'b1 && TX === 1'b0) begin
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = TX;
        end
        repeat (B) @(negedge clk);
        txq.push_back(b);
      end
      prev = TX;
    end
  end

  task automatic pop_chk(input string name, input logic [7:0] exp);
    if (txq.size() > 0) begin
      chk(name, {8'd0, txq.pop_front()}, {8'd0, exp});
    end else begin
      nvec++;
      nerr++;
      $display("FAIL %s: no byte decoded on TX, expected %h", name, exp);
    end
  endtask

  task automatic do_send(input logic [15:0] w, output int n);
    cmd      = w;
    send_cmd = 1'b1;
    n        = 0;
    do begin
      @(posedge clk); #1;
      send_cmd = 1'b0;
      n++;
    end while (!cmd_sent && n < 3 * FRAME);
  endtask

  // Robot side: sync (2) + edge detect (1) + half bit + nine bit periods to the stop sample.
  task automatic robot_send(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    @(posedge clk); #1;
    rx_byte = b;
    det_e   = cyc + 3;
    done_e  = cyc + 3 + B / 2 + 9 * B;
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      repeat (B) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr_rx_rdy = 1'b1;
    @(posedge clk); #1;
    clr_rx_rdy = 1'b0;
  endtask

  initial begin : main
    int n;
    int n2;
    int rises;
    logic prev_sent;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx", {15'd0, TX}, 16'd1);
    chk("reset_cmd_sent", {15'd0, cmd_sent}, 16'd0);
    chk("reset_resp_rdy", {15'd0, resp_rdy}, 16'd0);
    chk("reset_resp", {8'd0, resp}, 16'h0000);
    rst_n    = 1'b1;
    check_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    do_send(16'h2000, n);
    chk("cal_latency", 16'(n), 16'd8681);
    pop_chk("cal_hi_byte", 8'h20);
    pop_chk("cal_lo_byte", 8'h00);

    cmd       = 16'h4A3C;
    send_cmd  = 1'b1;
    n         = 0;
    rises     = 0;
    prev_sent = cmd_sent;
    while (n < 2 * FRAME + 40) begin
      @(posedge clk); #1;
      n++;
      send_cmd = (n == 3000) || (n == 6000);
      if (n >= 3000) cmd = 16'hFFFF;
      if (cmd_sent && !prev_sent) rises++;
      prev_sent = cmd_sent;
    end
    chk("busy_cmd_sent_rises", 16'(rises), 16'd1);
    chk("busy_cmd_sent", {15'd0, cmd_sent}, 16'd1);
    pop_chk("busy_hi_byte", 8'h4A);
    pop_chk("busy_lo_byte", 8'h3C);
    chk("busy_no_extra_bytes", 16'(txq.size()), 16'd0);

    robot_send(8'hA5);
    chk("a5_rdy", {15'd0, resp_rdy}, 16'd1);
    chk("a5_resp", {8'd0, resp}, 16'h00A5);
    pulse_clr();
    chk("a5_clr_rdy", {15'd0, resp_rdy}, 16'd0);
    chk("a5_resp_hold", {8'd0, resp}, 16'h00A5);

    for (int i = 0; i < 3; i++) begin
      robot_send(8'h5A);
      chk("5a_rdy", {15'd0, resp_rdy}, 16'd1);
      chk("5a_resp", {8'd0, resp}, 16'h005A);
      pulse_clr();
      chk("5a_clr_rdy", {15'd0, resp_rdy}, 16'd0);
    end

    fork
      robot_send(8'hC3);
      begin
        @(posedge clk); #2;
        while (cyc < done_e - 1) begin
          @(posedge clk); #1;
        end
        clr_rx_rdy = 1'b1;
        @(posedge clk); #1;
        clr_rx_rdy = 1'b0;
        chk("same_cycle_rdy", {15'd0, resp_rdy}, 16'd1);
        chk("same_cycle_resp", {8'd0, resp}, 16'h00C3);
      end
    join
    pulse_clr();

    det_e = cyc + 3;
    RX    = 1'b0;
    @(posedge clk); #1;
    RX = 1'b1;
    repeat (FRAME) @(posedge clk);
    #1;
    chk("glitch_rdy", {15'd0, resp_rdy}, 16'd0);
    chk("glitch_resp", {8'd0, resp}, 16'h00C3);

    fork
      do_send(16'h4000, n2);
      robot_send(8'h5A);
    join
    chk("duplex_latency", 16'(n2), 16'd8681);
    chk("duplex_resp", {8'd0, resp}, 16'h005A);
    pop_chk("duplex_hi_byte", 8'h40);
    pop_chk("duplex_lo_byte", 8'h00);
    pulse_clr();

    cmd      = 16'h2000;
    send_cmd = 1'b1;
    @(posedge clk); #1;
    send_cmd = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_tx", {15'd0, TX}, 16'd1);
    chk("abort_cmd_sent", {15'd0, cmd_sent}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/remote_comm.md
Name: remote_comm

Overview:
- Host-side Bluetooth/UART command link for the Knight's Tour robot.
- Serializes a 16-bit command as two UART bytes, high byte first.
- Receives one-byte responses from the robot, e.g. the calibration-complete and per-move status codes.
- Sits between the test host/remote and the robot's UART.

Parameters:
- BAUD_DIV, 434, clock cycles per UART bit (9-bit counter minimum).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- RX  input  1  serial data from robot (asynchronous, idles high)
- TX  output  1  serial data to robot (idles high)
- cmd  input  16  command word to send
- send_cmd  input  1  one-cycle request to send cmd
- cmd_sent  output  1  high once both bytes are fully transmitted
- resp  output  8  last received response byte
- resp_rdy  output  1  a new response byte is held in resp
- clr_rx_rdy  input  1  one-cycle acknowledge; clears resp_rdy

Behaviour:
- Reset values: TX=1, cmd_sent=0, resp=8'h00, resp_rdy=0. All internal counters and state return to idle.
- One clock domain. rst_n is sampled on the clk edge (synchronous, active low).
- Reset mid-transfer aborts the transfer: TX returns high the next cycle.
- UART frame format (8N1): start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV cycles.
- Command FSM states: IDLE, SEND_HI, SEND_LO.
  - IDLE and send_cmd=1: latch cmd, clear cmd_sent, start transmitting cmd[15:8]. The start bit appears on TX the cycle after send_cmd.
  - SEND_HI, when its stop bit completes: start cmd[7:0] immediately, with no idle gap.
  - SEND_LO, when its stop bit completes: set cmd_sent=1, go to IDLE.
  - send_cmd while in SEND_HI or SEND_LO is ignored. The latched word is unaffected.
  - cmd_sent stays high until the next accepted send_cmd.
- Command latency: send_cmd to cmd_sent rising = 20*BAUD_DIV+1 cycles.
- Receiver:
  - RX is double-flop synchronized before use.
  - A falling edge while idle starts reception.
  - Sample points: start bit at BAUD_DIV/2 cycles; each following bit every BAUD_DIV cycles thereafter.
  - If the start bit sample reads 1, treat it as a glitch and return to idle.
  - Data bits shift in LSB first.
  - After the stop-bit sample: load resp and set resp_rdy. Framing errors (stop bit = 0) are ignored; the byte is still delivered.
- resp_rdy:
  - Cleared by clr_rx_rdy, or when a new start bit is detected.
  - If clr_rx_rdy and a byte completion occur in the same cycle, set wins.
  - resp holds its value until the next completed byte.
- Transmitter and receiver are fully independent. Full-duplex operation is required.

Optional Feature:
- Macro REMOTE_COMM_AUTO_CLR_EN.
- Defined: an accepted send_cmd also clears resp_rdy in that cycle.
- Undefined: resp_rdy is cleared only by clr_rx_rdy or a new start bit.
- The port list is identical in both builds.

Decomposition:
- Package comm_pkg holds:
  - Response codes: COMM_COMPLETE = 8'hA5, COMM_INTERMEDIATE = 8'h5A.
  - Command opcodes, including CALIBRATE = 16'h2000.
  - Default BAUD_DIV.
  - Command FSM state enum.
- One sub-module, uart_trx:
  - 8N1 transmitter (trmt, tx_data, tx_done).
  - Receiver (rx_data, rdy, clr_rdy).
  - Parameterized by BAUD_DIV.
- remote_comm contains only the two-byte command FSM and the rdy/cmd_sent glue.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00.
- Send cmd=16'h2000 -> TX carries byte 8'h20 then 8'h00, LSB first, each bit BAUD_DIV cycles; cmd_sent rises 20*BAUD_DIV+1 cycles after send_cmd.
- Send 16'h4A3C, then pulse send_cmd with 16'hFFFF mid-transfer -> only 8'h4A, 8'h3C appear on TX; cmd_sent=1 once, at end.
- Loop TX to RX via a robot model answering 8'hA5 -> resp=8'hA5, resp_rdy=1. Pulse clr_rx_rdy -> resp_rdy=0 next cycle, resp still 8'hA5.
- Three successive 8'h5A frames, each acknowledged with clr_rx_rdy -> resp_rdy asserts three times, resp=8'h5A each time.
- clr_rx_rdy asserted in the same cycle as a byte completes -> resp_rdy=1.
- 1-cycle low glitch on idle RX -> no reception, resp_rdy stays 0.
